sub_mem_ctrl: RTL and testbench
===============================

SUB_MEM_CTRL -- requirements
Module: sub_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data bus width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 32, address width in bits.
REQ-003 SHALL have parameter MEM_BYTES, default 4096, byte-addressed backing store depth.
REQ-004 SHALL have port ACLK  in  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port ARESET  in  1  synchronous, active-high reset.
REQ-006 SHALL have port aw_addr  in  ADDR_W  write address from AW RX channel latch.
REQ-007 SHALL have port aw_new  in  1  one-cycle pulse, aw_addr valid this cycle.
REQ-008 SHALL have port aw_hold  out  1  high = AW channel must deassert READY.
REQ-009 SHALL have port w_data  in  DATA_W  write data from W RX channel latch.
REQ-010 SHALL have port w_new  in  1  one-cycle pulse, w_data valid this cycle.
REQ-011 SHALL have port w_hold  out  1  high = W channel must deassert READY.
REQ-012 SHALL have port ar_addr  in  ADDR_W  read address from AR RX channel latch.
REQ-013 SHALL have port ar_new  in  1  one-cycle pulse, ar_addr valid this cycle.
REQ-014 SHALL have port ar_hold  out  1  high = AR channel must deassert READY.
REQ-015 SHALL have port b_resp  out  2  write response (resp_t: OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3).
REQ-016 SHALL have port b_tx_en  out  1  one-cycle pulse launching B transfer.
REQ-017 SHALL have port b_busy  in  1  B TX channel has VALID outstanding.
REQ-018 SHALL have port r_data  out  DATA_W  read data to R TX channel.
REQ-019 SHALL have port r_resp  out  2  read response (resp_t).
REQ-020 SHALL have port r_tx_en  out  1  one-cycle pulse launching R transfer.
REQ-021 SHALL have port r_busy  in  1  R TX channel has VALID outstanding.

Function
REQ-022 SHALL implement FSM states IDLE, WR_COLLECT, WR_MEM, WR_RESP, RD_MEM, RD_RESP.
REQ-023 SHALL capture aw_addr on aw_new and w_data on w_new in any state where the matching hold is low; capture sets a pending flag and raises that hold next cycle.
REQ-024 SHALL ignore and drop any *_new pulse arriving while its hold is high.
REQ-025 SHALL, in IDLE with only one of AW/W pending, go to WR_COLLECT; with both pending (incl. same-cycle aw_new and w_new), go to WR_MEM.
REQ-026 SHALL, in IDLE with a read pending and no complete write pair, go to RD_MEM.
REQ-027 SHALL, when a complete write pair and a read are both pending in IDLE, alternate priority using a last-served flag (reset value: last=read, so write wins first).
REQ-028 SHALL, in WR_MEM, store w_data little-endian at bytes addr..addr+DATA_W/8-1 in one cycle, then go to WR_RESP.
REQ-029 SHALL, in RD_MEM, register r_data little-endian from addr and r_resp, then go to RD_RESP.
REQ-030 SHALL, in WR_RESP/RD_RESP, pulse b_tx_en/r_tx_en in the first cycle b_busy/r_busy is low, clear the pending flags and holds that same cycle, and return to IDLE.
REQ-031 SHALL hold b_resp, r_data, r_resp stable from tx_en until the matching busy falls.
REQ-032 SHALL give latency: last of AW/W captured at cycle N -> b_tx_en at N+3 with b_busy low; ar_new at N -> r_tx_en at N+3 with r_busy low and no write pair pending.
REQ-033 SHALL use the low log2(MEM_BYTES) address bits as the memory index.

Reset
REQ-034 SHALL, on ARESET at any state, go to IDLE, clear pending flags and last-served flag, and drop in-flight transactions.
REQ-035 SHALL drive aw_hold, w_hold, ar_hold, b_tx_en, r_tx_en = 0, b_resp = r_resp = OKAY, r_data = 0 during and after reset.
REQ-036 SHALL NOT clear memory contents on reset.

Configuration
REQ-037 SHALL, with SUB_MEM_ADDR_CHECK_EN defined, respond DECERR for addr+DATA_W/8 > MEM_BYTES and SLVERR for addr not DATA_W/8-aligned, suppress the write, return r_data = 0, DECERR checked first.
REQ-038 SHALL, without SUB_MEM_ADDR_CHECK_EN, always respond OKAY and wrap byte indices modulo MEM_BYTES.

Verification
REQ-039 SHALL cover: aw_new addr=0x10, w_new data=0xDEADBEEF same cycle -> b_tx_en 3 cycles later, b_resp=OKAY; then ar_new 0x10 -> r_data=0xDEADBEEF, r_resp=OKAY.
REQ-040 SHALL cover: w_new 0x11223344 five cycles before aw_new 0x20 -> w_hold high in between, b_tx_en 3 cycles after aw_new; read 0x20 byte 0 = 0x44.
REQ-041 SHALL cover: write pair and ar_new pending together twice in a row -> served write, read, write, read.
REQ-042 SHALL cover: b_busy held high 4 cycles in WR_RESP -> b_tx_en delayed to first low cycle, aw_hold/w_hold high until then.
REQ-043 SHALL cover: with macro, write 0x1000 -> DECERR and memory unchanged; write 0x02 -> SLVERR; without macro, write 0x1000 -> OKAY, read 0x0 returns the data.
REQ-044 SHALL cover: ARESET asserted in WR_MEM -> all holds 0, no b_tx_en; prior memory data still readable.

Source files
------------

// File: rtl/sub_mem_ctrl.sv
// Byte-addressed memory slave core behind AXI-lite style RX/TX channel latches; capture to tx_en in 3 cycles.
// *_hold stalls a channel while its request is pending, *_busy stalls responses; SUB_MEM_ADDR_CHECK_EN adds range/alignment errors.
module sub_mem_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 4096
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [ADDR_W-1:0] aw_addr,
    input  logic              aw_new,
    output logic              aw_hold,
    input  logic [DATA_W-1:0] w_data,
    input  logic              w_new,
    output logic              w_hold,
    input  logic [ADDR_W-1:0] ar_addr,
    input  logic              ar_new,
    output logic              ar_hold,
    output logic [1:0]        b_resp,
    output logic              b_tx_en,
    input  logic              b_busy,
    output logic [DATA_W-1:0] r_data,
    output logic [1:0]        r_resp,
    output logic              r_tx_en,
    input  logic              r_busy
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = $clog2(MEM_BYTES);
    localparam logic [1:0] RESP_OKAY = 2'd0;

    typedef enum logic [2:0] {IDLE, WR_COLLECT, WR_MEM, WR_RESP, RD_MEM, RD_RESP} state_t;

    state_t            state_q, state_d;
    logic              aw_pend_q, aw_pend_d;
    logic              w_pend_q, w_pend_d;
    logic              ar_pend_q, ar_pend_d;
    logic              last_wr_q;
    logic [ADDR_W-1:0] aw_addr_q, ar_addr_q;
    logic [DATA_W-1:0] w_data_q;
    logic [1:0]        b_resp_q, r_resp_q;
    logic [DATA_W-1:0] r_data_q;
    logic [7:0]        mem_q [MEM_BYTES];
    logic [DATA_W-1:0] rd_word;
    logic [1:0]        wr_chk, rd_chk;
    logic              wr_done, rd_done, aw_cap, w_cap, ar_cap, want_wr, want_rd;

`ifdef SUB_MEM_ADDR_CHECK_EN
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    // Range is tested on the full address so out-of-window accesses never alias.
    function automatic logic [1:0] addr_resp(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] end_a;
        end_a = {1'b0, a} + (ADDR_W+1)'(NB);
        if (end_a > (ADDR_W+1)'(MEM_BYTES)) return RESP_DECERR;
        if ((a & ADDR_W'(NB - 1)) != '0) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    assign wr_chk = addr_resp(aw_addr_q);
    assign rd_chk = addr_resp(ar_addr_q);
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^{aw_addr_q[ADDR_W-1:IDX_W], ar_addr_q[ADDR_W-1:IDX_W]};
    assign wr_chk = RESP_OKAY;
    assign rd_chk = RESP_OKAY;
`endif

    assign wr_done = (state_q == WR_RESP) && !b_busy;
    assign rd_done = (state_q == RD_RESP) && !r_busy;

    // Holds drop in the launch cycle so the next request can be taken without a bubble.
    assign aw_hold = !ARESET && aw_pend_q && !wr_done;
    assign w_hold  = !ARESET && w_pend_q && !wr_done;
    assign ar_hold = !ARESET && ar_pend_q && !rd_done;
    assign b_tx_en = !ARESET && wr_done;
    assign r_tx_en = !ARESET && rd_done;
    assign b_resp  = b_resp_q;
    assign r_resp  = r_resp_q;
    assign r_data  = r_data_q;

    assign aw_cap = aw_new && !aw_hold;
    assign w_cap  = w_new && !w_hold;
    assign ar_cap = ar_new && !ar_hold;

    assign aw_pend_d = aw_cap || (aw_pend_q && !wr_done);
    assign w_pend_d  = w_cap || (w_pend_q && !wr_done);
    assign ar_pend_d = ar_cap || (ar_pend_q && !rd_done);

    // A new access waits for its TX channel so the previous response stays stable.
    assign want_wr = aw_pend_q && w_pend_q && !b_busy;
    assign want_rd = ar_pend_q && !r_busy;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, WR_COLLECT: begin
                if (want_wr && (!want_rd || !last_wr_q)) state_d = WR_MEM;
                else if (want_rd)                        state_d = RD_MEM;
                else if (aw_pend_q || w_pend_q)          state_d = WR_COLLECT;
                else                                     state_d = IDLE;
            end
            WR_MEM:  state_d = WR_RESP;
            WR_RESP: if (!b_busy) state_d = IDLE;
            RD_MEM:  state_d = RD_RESP;
            RD_RESP: if (!r_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NB; i++) begin
            rd_word[8*i +: 8] = mem_q[ar_addr_q[IDX_W-1:0] + IDX_W'(i)];
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= IDLE;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            ar_pend_q <= 1'b0;
            last_wr_q <= 1'b0;
            b_resp_q  <= RESP_OKAY;
            r_resp_q  <= RESP_OKAY;
            r_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            ar_pend_q <= ar_pend_d;
            if (aw_cap) aw_addr_q <= aw_addr;
            if (w_cap)  w_data_q  <= w_data;
            if (ar_cap) ar_addr_q <= ar_addr;
            if (state_q == WR_MEM) begin
                b_resp_q  <= wr_chk;
                last_wr_q <= 1'b1;
            end
            if (state_q == RD_MEM) begin
                r_data_q  <= (rd_chk == RESP_OKAY) ? rd_word : '0;
                r_resp_q  <= rd_chk;
                last_wr_q <= 1'b0;
            end
        end
    end

    // Backing store is never reset; a write caught by reset is dropped.
    always_ff @(posedge ACLK) begin
        if (!ARESET && state_q == WR_MEM && wr_chk == RESP_OKAY) begin
            for (int i = 0; i < NB; i++) begin
                mem_q[aw_addr_q[IDX_W-1:0] + IDX_W'(i)] <= w_data_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_sub_mem_ctrl.sv
// Directed bench for sub_mem_ctrl: latency, hold behaviour, arbitration, busy stall, address checks, reset.
module tb_sub_mem_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] aw_addr, w_data, ar_addr, r_data;
    logic        aw_new, w_new, ar_new, aw_hold, w_hold, ar_hold;
    logic [1:0]  b_resp, r_resp;
    logic        b_tx_en, b_busy, r_tx_en, r_busy;

    int checks   = 0;
    int failures = 0;

    always #5 ACLK = ~ACLK;

    sub_mem_ctrl dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .aw_addr(aw_addr), .aw_new(aw_new), .aw_hold(aw_hold),
        .w_data(w_data), .w_new(w_new), .w_hold(w_hold),
        .ar_addr(ar_addr), .ar_new(ar_new), .ar_hold(ar_hold),
        .b_resp(b_resp), .b_tx_en(b_tx_en), .b_busy(b_busy),
        .r_data(r_data), .r_resp(r_resp), .r_tx_en(r_tx_en), .r_busy(r_busy)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Entered in the cycle after the request pulse; the pulse cycle counts as 0.
    task automatic wait_b(input string tag, input logic [1:0] er);
        int lat;
        lat = 1;
        forever begin
            @(negedge ACLK);
            if (b_tx_en || lat >= 12) break;
            @(posedge ACLK); #1;
            lat++;
        end
        chk({tag, "_blat"}, 64'(lat), 64'd3);
        chk({tag, "_bresp"}, 64'(b_resp), 64'(er));
    endtask

    task automatic wait_r(input string tag, input logic [31:0] ed, input logic [1:0] er);
        int lat;
        lat = 1;
        forever begin
            @(negedge ACLK);
            if (r_tx_en || lat >= 12) break;
            @(posedge ACLK); #1;
            lat++;
        end
        chk({tag, "_rlat"}, 64'(lat), 64'd3);
        chk({tag, "_rdata"}, 64'(r_data), 64'(ed));
        chk({tag, "_rresp"}, 64'(r_resp), 64'(er));
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [1:0] er);
        @(posedge ACLK); #1;
        aw_addr = a; w_data = d; aw_new = 1'b1; w_new = 1'b1;
        @(posedge ACLK); #1;
        aw_new = 1'b0; w_new = 1'b0;
        wait_b(tag, er);
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
        @(posedge ACLK); #1;
        ar_addr = a; ar_new = 1'b1;
        @(posedge ACLK); #1;
        ar_new = 1'b0;
        wait_r(tag, ed, er);
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  order;
        logic [31:0] first_rd, last_rd;
        int nev, nw, nr, tx_cnt, hold_low;

        ARESET = 1'b1; aw_addr = '0; w_data = '0; ar_addr = '0;
        aw_new = 1'b0; w_new = 1'b0; ar_new = 1'b0; b_busy = 1'b0; r_busy = 1'b0;
        order = '0; first_rd = '0; last_rd = '0;
        nev = 0; nw = 0; nr = 0; tx_cnt = 0; hold_low = 0;

        // Reset state, with requests pulsing to show nothing leaks through.
        repeat (2) @(posedge ACLK);
        #1; aw_new = 1'b1; w_new = 1'b1; ar_new = 1'b1;
        @(negedge ACLK);
        chk("rst_holds", {61'd0, aw_hold, w_hold, ar_hold}, 64'd0);
        chk("rst_tx_en", {62'd0, b_tx_en, r_tx_en}, 64'd0);
        chk("rst_resp", {60'd0, b_resp, r_resp}, 64'd0);
        chk("rst_rdata", 64'(r_data), 64'd0);
        @(posedge ACLK); #1;
        aw_new = 1'b0; w_new = 1'b0; ar_new = 1'b0; ARESET = 1'b0;
        @(negedge ACLK);
        chk("post_rst_holds", {61'd0, aw_hold, w_hold, ar_hold}, 64'd0);

        // Same-cycle AW/W, then read back.
        do_write("w10", 32'h10, 32'hDEADBEEF, 2'd0);
        do_read("r10", 32'h10, 32'hDEADBEEF, 2'd0);

        // W well ahead of AW; a second W while held must be dropped.
        @(posedge ACLK); #1; w_data = 32'h11223344; w_new = 1'b1;
        @(posedge ACLK); #1; w_new = 1'b0;
        @(negedge ACLK); chk("w_early_hold1", 64'(w_hold), 64'd1);
        @(posedge ACLK); #1; w_data = 32'h55667788; w_new = 1'b1;
        @(negedge ACLK); chk("w_early_hold2", {62'd0, w_hold, aw_hold}, 64'd2);
        @(posedge ACLK); #1; w_new = 1'b0;
        @(negedge ACLK); chk("w_early_hold3", 64'(w_hold), 64'd1);
        @(posedge ACLK); #1;
        @(negedge ACLK); chk("w_early_no_b", 64'(b_tx_en), 64'd0);
        @(posedge ACLK); #1; aw_addr = 32'h20; aw_new = 1'b1;
        @(posedge ACLK); #1; aw_new = 1'b0;
        wait_b("w20", 2'd0);
        do_read("r20", 32'h20, 32'h11223344, 2'd0);
        chk("r20_byte0", 64'(r_data[7:0]), 64'h44);

        // Write pair and read pending together twice: priority must alternate.
        @(posedge ACLK); #1;
        aw_addr = 32'h30; w_data = 32'h0A0B0C0D; ar_addr = 32'h10;
        aw_new = 1'b1; w_new = 1'b1; ar_new = 1'b1;
        for (int c = 0; c < 40 && nev < 4; c++) begin
            @(posedge ACLK); #1;
            aw_new = 1'b0; w_new = 1'b0; ar_new = 1'b0;
            @(negedge ACLK);
            if (b_tx_en) begin
                order = {order[2:0], 1'b1}; nev++; nw++;
                if (nw == 1) begin
                    aw_addr = 32'h34; w_data = 32'h0E0F1011; aw_new = 1'b1; w_new = 1'b1;
                end
            end
            if (r_tx_en) begin
                order = {order[2:0], 1'b0}; nev++; nr++;
                if (nr == 1) begin
                    first_rd = r_data; ar_addr = 32'h30; ar_new = 1'b1;
                end else begin
                    last_rd = r_data;
                end
            end
        end
        chk("arb_events", 64'(nev), 64'd4);
        chk("arb_order", 64'(order), 64'b1010);
        chk("arb_rd1", 64'(first_rd), 64'hDEADBEEF);
        chk("arb_rd2", 64'(last_rd), 64'h0A0B0C0D);

        // B channel busy for 4 cycles of WR_RESP.
        @(posedge ACLK); #1; aw_addr = 32'h50; w_data = 32'h01020304; aw_new = 1'b1; w_new = 1'b1;
        @(posedge ACLK); #1; aw_new = 1'b0; w_new = 1'b0;
        @(posedge ACLK); #1; b_busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge ACLK); #1;
            @(negedge ACLK);
            if (b_tx_en) tx_cnt++;
            if (!aw_hold || !w_hold) hold_low++;
        end
        chk("busy_no_tx", 64'(tx_cnt), 64'd0);
        chk("busy_holds", 64'(hold_low), 64'd0);
        @(posedge ACLK); #1; b_busy = 1'b0;
        @(negedge ACLK);
        chk("busy_release_tx", 64'(b_tx_en), 64'd1);
        chk("busy_release_resp", 64'(b_resp), 64'd0);
        @(posedge ACLK); #1;
        @(negedge ACLK);
        chk("busy_after", {62'd0, b_tx_en, aw_hold}, 64'd0);

        // Address range / alignment handling.
        do_write("w0", 32'h0, 32'hA5A5A5A5, 2'd0);
`ifdef SUB_MEM_ADDR_CHECK_EN
        do_write("w1000", 32'h1000, 32'h12345678, 2'd3);
        do_read("r0_a", 32'h0, 32'hA5A5A5A5, 2'd0);
        do_write("w2", 32'h2, 32'hFFFFFFFF, 2'd2);
        do_read("r0_b", 32'h0, 32'hA5A5A5A5, 2'd0);
        do_read("r1000", 32'h1000, 32'h0, 2'd3);
        do_read("rffe", 32'hFFE, 32'h0, 2'd3);
        do_read("r2", 32'h2, 32'h0, 2'd2);
`else
        do_write("w1000", 32'h1000, 32'h12345678, 2'd0);
        do_read("r0_a", 32'h0, 32'h12345678, 2'd0);
        do_read("r1000", 32'h1000, 32'h12345678, 2'd0);
        do_write("wffe", 32'hFFE, 32'hAABBCCDD, 2'd0);
        do_read("r0_b", 32'h0, 32'h1234AABB, 2'd0);
        do_read("rffe", 32'hFFE, 32'hAABBCCDD, 2'd0);
`endif

        // Reset landing in WR_MEM drops the write without touching stored data.
        tx_cnt = 0; hold_low = 0;
        @(posedge ACLK); #1; aw_addr = 32'h40; w_data = 32'hCAFEF00D; aw_new = 1'b1; w_new = 1'b1;
        @(posedge ACLK); #1; aw_new = 1'b0; w_new = 1'b0;
        @(negedge ACLK); chk("rstw_hold_pre", 64'(aw_hold), 64'd1);
        @(posedge ACLK); #1; ARESET = 1'b1;
        @(negedge ACLK);
        chk("rstw_holds", {61'd0, aw_hold, w_hold, ar_hold}, 64'd0);
        chk("rstw_tx", 64'(b_tx_en), 64'd0);
        @(posedge ACLK); #1; ARESET = 1'b0;
        @(negedge ACLK); chk("rstw_rdata", 64'(r_data), 64'd0);
        for (int k = 0; k < 6; k++) begin
            @(posedge ACLK); #1;
            @(negedge ACLK);
            if (b_tx_en) tx_cnt++;
            if (aw_hold || w_hold) hold_low++;
        end
        chk("rstw_no_tx", 64'(tx_cnt), 64'd0);
        chk("rstw_holds_after", 64'(hold_low), 64'd0);
        do_read("rstw_r10", 32'h10, 32'hDEADBEEF, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
